// File: rtl/fifo_stream_pkg.sv
// Register map, bit positions and sizing helpers shared by the APB sample FIFO stream.
// Keep the offsets here so firmware headers can be generated from a single source.
package fifo_stream_pkg;

   localparam logic [7:0] ADDR_DATA   = 8'h00;
   localparam logic [7:0] ADDR_CTRL   = 8'h04;
   localparam logic [7:0] ADDR_STATUS = 8'h08;
   localparam logic [7:0] ADDR_THRESH = 8'h0C;

   localparam int CTRL_ENABLE   = 0;
   localparam int CTRL_FLUSH    = 1;
   localparam int CTRL_RATE_LSB = 8;

   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_ALM_EMPTY = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_UDF       = 4;
   localparam int ST_LEVEL_LSB = 16;

   typedef enum logic [2:0] {
      REG_DATA,
      REG_CTRL,
      REG_STATUS,
      REG_THRESH,
      REG_INVALID
   } reg_sel_e;

   // Level needs one extra bit over the pointers so that "full" is representable.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic reg_sel_e decode_addr(input logic [7:0] addr);
      reg_sel_e sel;
      case (addr)
         ADDR_DATA:   sel = REG_DATA;
         ADDR_CTRL:   sel = REG_CTRL;
         ADDR_STATUS: sel = REG_STATUS;
         ADDR_THRESH: sel = REG_THRESH;
         default:     sel = REG_INVALID;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// DEPTH x WIDTH synchronous FIFO storage with free-running wrapping pointers and an explicit level.
// Flush has priority over push and pop; full/empty are registered from the next level.
module fifo_sync_mem
   import fifo_stream_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  logic [WIDTH-1:0]        din,
   output logic [WIDTH-1:0]        dout,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    full,
   output logic                    empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = lvl_w(DEPTH);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push && !full_q && !flush;
      do_pop   = pop && !empty_q && !flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
         else if (!do_push && do_pop) level_d = level_q - LVL_W'(1);
      end
      full_d  = (level_d == LVL_FULL);
      empty_d = (level_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage needs no reset: entries are only observed after being written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign level = level_q;
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: rtl/apb_fifo_stream.sv
// APB-fed sample FIFO drained by a symbol-rate-paced valid/ready output stage.
// Holds the register file, sticky flags, rate divider and the output register.
module apb_fifo_stream
   import fifo_stream_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 64,
   parameter int RATE_W  = 8,
   parameter int PDATA_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         paddr,
   input  logic               psel,
   input  logic               penable,
   input  logic               pwrite,
   input  logic [PDATA_W-1:0] pwdata,
   output logic [PDATA_W-1:0] prdata,
   output logic               pready,
   output logic               pslverr,
   output logic [WIDTH-1:0]   data_out,
   output logic               data_valid,
   input  logic               data_ready,
   output logic               IQ_rate,
   output logic               mem_state,
   output logic               irq_alm_empty
);

   localparam int LVL_W = lvl_w(DEPTH);
   localparam logic [LVL_W-1:0] THRESH_RST = LVL_W'(DEPTH / 4);

   reg_sel_e           sel;
   logic               access;
   logic               push, flush, ovf_set, ovf_clr, udf_clr, ctrl_we, thresh_we;
   logic [PDATA_W-1:0] rdata;
   logic               slverr;
   logic               unused_pwdata;

   logic               enable_q, enable_d;
   logic [RATE_W-1:0]  rate_div_q, rate_div_d;
   logic [RATE_W-1:0]  cnt_q, cnt_d;
   logic [LVL_W-1:0]   thresh_q, thresh_d;
   logic [WIDTH-1:0]   dout_q, dout_d;
   logic               dv_q, dv_d;
   logic               ovf_q, ovf_d;
   logic               udf_q, udf_d;
   logic               irq_q, irq_d;
   logic               tick, load;

   logic [WIDTH-1:0]   fifo_head;
   logic [LVL_W-1:0]   fifo_level;
   logic               fifo_full, fifo_empty;

   assign access        = psel && penable;
   assign sel           = decode_addr(paddr);
   assign unused_pwdata = ^pwdata;

   // APB decode: read data and error are only driven during the access phase.
   always_comb begin
      rdata     = '0;
      slverr    = 1'b0;
      push      = 1'b0;
      flush     = 1'b0;
      ovf_set   = 1'b0;
      ovf_clr   = 1'b0;
      udf_clr   = 1'b0;
      ctrl_we   = 1'b0;
      thresh_we = 1'b0;
      if (access) begin
         case (sel)
            REG_DATA: begin
               if (pwrite) begin
                  if (fifo_full) begin
                     slverr  = 1'b1;
                     ovf_set = 1'b1;
                  end else begin
                     push = 1'b1;
                  end
               end
            end
            REG_CTRL: begin
               if (pwrite) begin
                  ctrl_we = 1'b1;
                  flush   = pwdata[CTRL_FLUSH];
               end else begin
                  rdata[CTRL_ENABLE]              = enable_q;
                  rdata[CTRL_RATE_LSB +: RATE_W]  = rate_div_q;
               end
            end
            REG_STATUS: begin
               if (pwrite) begin
                  ovf_clr = pwdata[ST_OVF];
                  udf_clr = pwdata[ST_UDF];
               end else begin
                  rdata[ST_EMPTY]               = fifo_empty;
                  rdata[ST_FULL]                = fifo_full;
                  rdata[ST_ALM_EMPTY]           = irq_q;
                  rdata[ST_OVF]                 = ovf_q;
                  rdata[ST_UDF]                 = udf_q;
                  rdata[ST_LEVEL_LSB +: LVL_W]  = fifo_level;
               end
            end
            REG_THRESH: begin
               if (pwrite) thresh_we = 1'b1;
               else        rdata[LVL_W-1:0] = thresh_q;
            end
            default: slverr = 1'b1;
         endcase
      end
   end

   // Rate divider, output stage and sticky flags; a tick lost to a stall never pops.
   always_comb begin
      enable_d   = ctrl_we ? pwdata[CTRL_ENABLE] : enable_q;
      rate_div_d = ctrl_we ? pwdata[CTRL_RATE_LSB +: RATE_W] : rate_div_q;
      thresh_d   = thresh_we ? pwdata[LVL_W-1:0] : thresh_q;

      tick  = enable_q && (cnt_q == rate_div_q);
      cnt_d = (enable_q && !tick) ? cnt_q + RATE_W'(1) : '0;

      load   = tick && !fifo_empty && (!dv_q || data_ready);
      dout_d = dout_q;
      dv_d   = dv_q;
      if (flush) begin
         dv_d = 1'b0;
      end else if (load) begin
         dout_d = fifo_head;
         dv_d   = 1'b1;
      end else if (dv_q && data_ready) begin
         dv_d = 1'b0;
      end

      ovf_d = (ovf_q && !ovf_clr) || ovf_set;
      udf_d = (udf_q && !udf_clr) || (tick && fifo_empty && !dv_q);
      irq_d = enable_q && (fifo_level <= thresh_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         enable_q   <= 1'b0;
         rate_div_q <= '0;
         cnt_q      <= '0;
         thresh_q   <= THRESH_RST;
         dout_q     <= '0;
         dv_q       <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         enable_q   <= enable_d;
         rate_div_q <= rate_div_d;
         cnt_q      <= cnt_d;
         thresh_q   <= thresh_d;
         dout_q     <= dout_d;
         dv_q       <= dv_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         irq_q      <= irq_d;
      end
   end

   fifo_sync_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (load),
      .flush (flush),
      .din   (pwdata[WIDTH-1:0]),
      .dout  (fifo_head),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign prdata        = rdata;
   assign pslverr       = slverr;
   assign pready        = 1'b1;
   assign data_out      = dout_q;
   assign data_valid    = dv_q;
   assign IQ_rate       = tick;
   assign mem_state     = !fifo_empty;
   assign irq_alm_empty = irq_q;

endmodule
